// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared encodings and constants for the bit-serial adder
// Contents:
//   state_t     controller states (IDLE=0, RUN=1, DONE=2)
//   WIDTH_MIN   smallest legal operand width
//   WIDTH_MAX   largest legal operand width
//   count_bits  bit-counter width for a given operand width (at least 1)
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  function automatic int count_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fa.sv
// rtl/fa.sv - single-bit full-adder cell, the only arithmetic in the serial adder
// Ports:
//   A, B   in   operand bits
//   Cin    in   carry in
//   Sum    out  sum bit
//   Cout   out  carry out
module fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around one shared full-adder
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand request valid
//   in_ready   out  operand request can be accepted (IDLE)
//   A, B       in   WIDTH-bit operands
//   Sub        in   0: A+B, 1: A-B
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer takes result
//   Sum        out  WIDTH-bit result, held until the next result
//   Cout       out  carry out of MSB (subtract: 1 = no borrow)
//   Ovf        out  signed overflow
//   busy       out  high in RUN or DONE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy
);

  localparam int CW = count_bits(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  // Bit position just below the MSB; for WIDTH=1 it coincides with the only bit.
  localparam logic [CW-1:0] CNT_PEN  = CW'((WIDTH > 1) ? (WIDTH - 2) : 0);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic [CW-1:0]    count;
  logic             carry, cmsb, cin_msb;
  logic             accept, last_bit;
  logic             fa_sum, fa_cout;

  fa u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_nxt = fa_sum;
  end else begin : g_sum_wn
    assign sum_nxt = {fa_sum, sum_sh[WIDTH-1:1]};
  end

  // With a single bit, the carry into the MSB is the carry register itself.
  assign cin_msb  = (WIDTH == 1) ? carry : cmsb;
  assign last_bit = (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      count  <= '0;
      carry  <= 1'b0;
      cmsb   <= 1'b0;
      Sum    <= '0;
      Cout   <= 1'b0;
      Ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
            a_sh  <= A;
            b_sh  <= Sub ? ~B : B;
            carry <= Sub;
            count <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_cout;
          count  <= count + CW'(1);
          if (count == CNT_PEN) begin
            cmsb <= (WIDTH == 1) ? carry : fa_cout;
          end
          if (last_bit) begin
            Sum  <= sum_nxt;
            Cout <= fa_cout;
            Ovf  <= cin_msb ^ fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       in_valid8, in_ready8, Sub8, out_valid8, out_ready8, Cout8, Ovf8, busy8;
  logic [7:0] A8, B8, Sum8;

  logic       in_valid1, in_ready1, Sub1, out_valid1, out_ready1, Cout1, Ovf1, busy1;
  logic [0:0] A1, B1, Sum1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .Sub(Sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .Sum(Sum8), .Cout(Cout8), .Ovf(Ovf8), .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .A(A1), .B(B1), .Sub(Sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .Sum(Sum1), .Cout(Cout1), .Ovf(Ovf1), .busy(busy1)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;

  // Plain-integer reference: A + (Sub ? ~B : B) + Sub, overflow from carries into/out of MSB.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub);
    logic [63:0] mask, m1, bb, full, low;
    exp_t e;
    mask  = (64'd1 << w) - 64'd1;
    m1    = (64'd1 << (w - 1)) - 64'd1;
    bb    = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    full  = ({32'd0, a} & mask) + bb + {63'd0, sub};
    low   = ({32'd0, a} & m1) + (bb & m1) + {63'd0, sub};
    e.sum  = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = low[w-1] ^ full[w];
    return e;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- WIDTH=8 helpers ----------------
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit push);
    @(negedge clk);
    chk1("in_ready8_before_accept", in_ready8, 1'b1);
    A8 = a; B8 = b; Sub8 = s; in_valid8 = 1'b1;
    @(posedge clk);
    if (push) q8.push_back(model(8, {24'd0, a}, {24'd0, b}, s));
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  // Latency counts edges from the accepting edge inclusive; starts at the negedge after accept.
  task automatic wait_valid8(input string tag, output exp_t e);
    int lat;
    lat = 1;
    while (!out_valid8 && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk32({tag, "_latency"}, lat, 32'd9);
    if (q8.size() == 0) begin
      chk1({tag, "_scoreboard_nonempty"}, 1'b0, 1'b1);
      e = '0;
    end else begin
      e = q8.pop_front();
      chk32({tag, "_sum"}, {24'd0, Sum8}, e.sum);
      chk1({tag, "_cout"}, Cout8, e.cout);
      chk1({tag, "_ovf"}, Ovf8, e.ovf);
    end
  endtask

  task automatic handshake8(input string tag);
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    chk1({tag, "_out_valid_drop"}, out_valid8, 1'b0);
    chk1({tag, "_in_ready_back"}, in_ready8, 1'b1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    accept8(a, b, s, 1'b1);
    wait_valid8(tag, e);
    handshake8(tag);
  endtask

  // ---------------- WIDTH=1 helper ----------------
  task automatic op1(input string tag, input logic a, input logic b, input logic s);
    exp_t e;
    int lat;
    @(negedge clk);
    chk1({tag, "_in_ready1"}, in_ready1, 1'b1);
    A1 = a; B1 = b; Sub1 = s; in_valid1 = 1'b1;
    @(posedge clk);
    q1.push_back(model(1, {31'd0, a}, {31'd0, b}, s));
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk32({tag, "_latency"}, lat, 32'd2);
    e = q1.pop_front();
    chk1({tag, "_sum"}, Sum1[0], e.sum[0]);
    chk1({tag, "_cout"}, Cout1, e.cout);
    chk1({tag, "_ovf"}, Ovf1, e.ovf);
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    chk1({tag, "_out_valid_drop"}, out_valid1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] held_sum;
    logic       held_cout, held_ovf;

    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; A8 = '0; B8 = '0; Sub8 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; A1 = '0; B1 = '0; Sub1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk1("rst_in_ready8", in_ready8, 1'b1);
    chk1("rst_out_valid8", out_valid8, 1'b0);
    chk1("rst_busy8", busy8, 1'b0);
    chk32("rst_sum8", {24'd0, Sum8}, 32'd0);
    chk1("rst_cout8", Cout8, 1'b0);
    chk1("rst_ovf8", Ovf8, 1'b0);
    chk1("rst_in_ready1", in_ready1, 1'b1);
    chk1("rst_out_valid1", out_valid1, 1'b0);
    rst = 1'b0;

    // Directed arithmetic cases, including the signed-overflow boundaries
    op8("ff_plus_01", 8'hFF, 8'h01, 1'b0);
    op8("05_minus_07", 8'h05, 8'h07, 1'b1);
    op8("07_minus_05", 8'h07, 8'h05, 1'b1);
    op8("7f_plus_01", 8'h7F, 8'h01, 1'b0);
    op8("80_minus_01", 8'h80, 8'h01, 1'b1);
    op8("00_minus_00", 8'h00, 8'h00, 1'b1);
    op8("80_plus_80", 8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 6; i++) begin
      op8("random_op", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Backpressure: in_valid held high through RUN/DONE must not start another op
    accept8(8'h3C, 8'h45, 1'b0, 1'b1);
    A8 = 8'hAA; B8 = 8'h55; Sub8 = 1'b1; in_valid8 = 1'b1;
    chk1("bp_busy_in_run", busy8, 1'b1);
    chk1("bp_in_ready_in_run", in_ready8, 1'b0);
    wait_valid8("bp", e);
    held_sum = Sum8; held_cout = Cout8; held_ovf = Ovf8;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk1("bp_out_valid_held", out_valid8, 1'b1);
      chk1("bp_in_ready_low", in_ready8, 1'b0);
      chk32("bp_sum_stable", {24'd0, Sum8}, e.sum);
      chk1("bp_cout_stable", Cout8, held_cout);
      chk1("bp_ovf_stable", Ovf8, held_ovf);
    end
    in_valid8 = 1'b0;
    handshake8("bp");
    chk32("bp_sum_after_leave", {24'd0, Sum8}, {24'd0, held_sum});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk1("bp_no_queued_op", out_valid8, 1'b0);
    end
    chk32("bp_scoreboard_empty", q8.size(), 32'd0);

    // Reset mid-RUN at count=3: partial result discarded
    accept8(8'h55, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk1("mid_busy_before_rst", busy8, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("mid_rst_out_valid", out_valid8, 1'b0);
    chk32("mid_rst_sum", {24'd0, Sum8}, 32'd0);
    chk1("mid_rst_in_ready", in_ready8, 1'b1);
    chk1("mid_rst_busy", busy8, 1'b0);
    op8("10_plus_20_after_rst", 8'h10, 8'h20, 1'b0);

    // WIDTH=1 instance
    op1("w1_1_plus_1", 1'b1, 1'b1, 1'b0);
    op1("w1_1_minus_1", 1'b1, 1'b1, 1'b1);
    op1("w1_0_minus_1", 1'b0, 1'b1, 1'b1);
    op1("w1_1_plus_0", 1'b1, 1'b0, 1'b0);
    op1("w1_0_plus_0", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
